// File: rtl/k16_pkg.sv
// Shared K16 definitions: memory-op and LSU state encodings plus op helpers,
// reused by the CPU decoder and the load/store unit.
package k16_pkg;

    typedef enum logic [1:0] {
        OP_LD  = 2'd0,
        OP_ST  = 2'd1,
        OP_PSH = 2'd2,
        OP_POP = 2'd3
    } k16_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } k16_lsu_state_e;

    localparam int WAIT_W = 4;

    function automatic logic op_is_write(input k16_op_e op);
        return (op == OP_ST) || (op == OP_PSH);
    endfunction

    function automatic logic op_is_stack(input k16_op_e op);
        return (op == OP_PSH) || (op == OP_POP);
    endfunction

endpackage

// File: rtl/k16_lsu_if.sv
// Request/response/memory bundle between the K16 core, its LSU and data memory.
interface k16_lsu_if
    import k16_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) ();
    logic              req_valid;
    logic              req_ready;
    k16_op_e           req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [ADDR_W-1:0] sp_in;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_zero;
    logic              resp_negative;
    logic [ADDR_W-1:0] sp_out;
    logic              sp_we;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_hold;

    logic              busy;

    // The LSU side.
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, sp_in, mem_rdata, mem_hold,
        output req_ready, resp_valid, resp_rdata, resp_zero, resp_negative,
               sp_out, sp_we, mem_address, mem_wdata, mem_write, busy
    );

    // The core plus memory side.
    modport master (
        output req_valid, req_op, req_addr, req_wdata, sp_in, mem_rdata, mem_hold,
        input  req_ready, resp_valid, resp_rdata, resp_zero, resp_negative,
               sp_out, sp_we, mem_address, mem_wdata, mem_write, busy
    );

endinterface

// File: rtl/k16_wait_timer.sv
// Wait-state down-counter: loads on request acceptance, decrements only while
// enabled (memory not stalled) and saturates at zero.
module k16_wait_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && !o_zero) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/k16_lsu.sv
// K16 load/store unit: one outstanding LD/ST/PSH/POP access with programmable
// wait states, memory stall support and stack-pointer update on completion.
module k16_lsu
    import k16_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1,
    parameter int STACK_DOWN  = 1
) (
    input  logic     clk,
    input  logic     reset,
    k16_lsu_if.slave bus
);
    k16_lsu_state_e    r_state;
    k16_lsu_state_e    w_state_next;
    k16_op_e           r_op;
    logic [ADDR_W-1:0] r_mem_address;
    logic [ADDR_W-1:0] r_sp_out;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_zero;
    logic              r_resp_negative;

    logic [ADDR_W-1:0] w_sp_plus;
    logic [ADDR_W-1:0] w_sp_minus;
    logic [ADDR_W-1:0] w_sp_push;
    logic [ADDR_W-1:0] w_pop_addr;
    logic [ADDR_W-1:0] w_access_addr;
    logic [ADDR_W-1:0] w_sp_next;
    logic              w_accept;
    logic              w_dec;
    logic              w_timer_zero;
    logic              w_access_exit;

    // Stack arithmetic wraps naturally at ADDR_W bits.
    assign w_sp_plus  = bus.sp_in + ADDR_W'(1);
    assign w_sp_minus = bus.sp_in - ADDR_W'(1);

    generate
        if (STACK_DOWN != 0) begin : g_stack_down
            assign w_sp_push  = w_sp_minus;
            assign w_pop_addr = w_sp_plus;
        end else begin : g_stack_up
            assign w_sp_push  = w_sp_plus;
            assign w_pop_addr = w_sp_minus;
        end
    endgenerate

    always_comb begin
        w_access_addr = bus.req_addr;
        w_sp_next     = bus.sp_in;
        case (bus.req_op)
            OP_PSH: begin
                w_access_addr = bus.sp_in;
                w_sp_next     = w_sp_push;
            end
            OP_POP: begin
                w_access_addr = w_pop_addr;
                w_sp_next     = w_pop_addr;
            end
            default: begin
                w_access_addr = bus.req_addr;
                w_sp_next     = bus.sp_in;
            end
        endcase
    end

    assign w_accept      = (r_state == ST_IDLE) && bus.req_valid;
    assign w_dec         = (r_state == ST_ACCESS) && !bus.mem_hold;
    assign w_access_exit = w_dec && w_timer_zero;

    k16_wait_timer #(
        .CNT_W (WAIT_W)
    ) u_wait_timer (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_accept),
        .i_load_val (WAIT_W'(WAIT_STATES)),
        .i_dec      (w_dec),
        .o_zero     (w_timer_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.req_valid) w_state_next = ST_ACCESS;
            ST_ACCESS: if (w_access_exit) w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op            <= OP_LD;
            r_mem_address   <= '0;
            r_mem_wdata     <= '0;
            r_sp_out        <= '0;
            r_resp_rdata    <= '0;
            r_resp_zero     <= 1'b0;
            r_resp_negative <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op          <= bus.req_op;
                r_mem_address <= w_access_addr;
                r_mem_wdata   <= bus.req_wdata;
                r_sp_out      <= w_sp_next;
            end
            // Read data is sampled on the same edge the access completes.
            if (w_access_exit) begin
                if (op_is_write(r_op)) begin
                    r_resp_rdata    <= '0;
                    r_resp_zero     <= 1'b0;
                    r_resp_negative <= 1'b0;
                end else begin
                    r_resp_rdata    <= bus.mem_rdata;
                    r_resp_zero     <= (bus.mem_rdata == '0);
                    r_resp_negative <= bus.mem_rdata[DATA_W-1];
                end
            end
        end
    end

    // Strobes decode straight from state so reset drops them instantly.
    assign bus.req_ready     = (r_state == ST_IDLE);
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.resp_valid    = (r_state == ST_DONE);
    assign bus.sp_we         = (r_state == ST_DONE) && op_is_stack(r_op);
    assign bus.mem_write     = (r_state == ST_ACCESS) && op_is_write(r_op);
    assign bus.mem_address   = r_mem_address;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.sp_out        = r_sp_out;
    assign bus.resp_rdata    = r_resp_rdata;
    assign bus.resp_zero     = r_resp_zero;
    assign bus.resp_negative = r_resp_negative;

endmodule

// File: tb/tb_k16_lsu.sv
// Bench for k16_lsu: transaction-level reference model with per-cycle compare,
// directed literal cases, randomized traffic and a WAIT_STATES=0 / stack-up instance.
`timescale 1ns/1ps
module tb_k16_lsu;
    import k16_pkg::*;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int WS = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    k16_lsu_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    k16_lsu_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

    k16_lsu #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(WS), .STACK_DOWN(1)) dut (
        .clk (clk), .reset (rst_n), .bus (bus)
    );
    k16_lsu #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(0), .STACK_DOWN(0)) dut2 (
        .clk (clk), .reset (rst2_n), .bus (bus2)
    );

    // Memory contents before any write: a few fixed cells, hash elsewhere.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        case (a)
            16'h0040: return 16'h8000;
            16'h0000: return 16'h0000;
            16'h0020: return 16'h0F0F;
            default:  return (a * 16'h9E37) ^ 16'h5A5A;
        endcase
    endfunction

    function automatic bit is_wr(input k16_op_e op);
        return (op == OP_ST) || (op == OP_PSH);
    endfunction

    function automatic bit is_stk(input k16_op_e op);
        return (op == OP_PSH) || (op == OP_POP);
    endfunction

    // Memory seen by the DUT.
    logic [15:0] mem    [0:65535];
    bit          mem_wr [0:65535];
    assign bus.mem_rdata  = mem_wr[bus.mem_address] ? mem[bus.mem_address] : init_val(bus.mem_address);
    assign bus2.mem_rdata = bus2.mem_address ^ 16'hA5A5;
    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem[bus.mem_address]    <= bus.mem_wdata;
            mem_wr[bus.mem_address] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference model: an accepted access needs WS+1 un-stalled access cycles,
    // then reports for one cycle; writes land on every access cycle.
    logic [15:0] mem_m  [0:65535];
    bit          m_wr   [0:65535];
    bit          m_busy, m_done;
    int          m_left;
    k16_op_e     m_op;
    logic [15:0] m_addr, m_wdata, m_sp, m_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_left > 0) begin
            if (is_wr(m_op)) begin
                mem_m[m_addr] = m_wdata;
                m_wr[m_addr]  = 1'b1;
            end
            if (!bus.mem_hold) begin
                m_left--;
                if (m_left == 0) begin
                    m_done  = 1'b1;
                    m_rdata = is_wr(m_op) ? 16'h0000 : (m_wr[m_addr] ? mem_m[m_addr] : init_val(m_addr));
                end
            end
        end else if (bus.req_valid) begin
            m_busy  = 1'b1;
            m_op    = bus.req_op;
            m_wdata = bus.req_wdata;
            m_left  = WS + 1;
            m_addr  = bus.req_addr;
            m_sp    = bus.sp_in;
            if (bus.req_op == OP_PSH) begin
                m_addr = bus.sp_in;
                m_sp   = bus.sp_in - 16'd1;
            end else if (bus.req_op == OP_POP) begin
                m_addr = bus.sp_in + 16'd1;
                m_sp   = m_addr;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_mem_write", bus.mem_write, 0);
            chk("rst_resp_valid", bus.resp_valid, 0);
            chk("rst_sp_we", bus.sp_we, 0);
            chk("rst_mem_address", bus.mem_address, 0);
            chk("rst_mem_wdata", bus.mem_wdata, 0);
            chk("rst_resp_rdata", bus.resp_rdata, 0);
            chk("rst_resp_flags", {bus.resp_zero, bus.resp_negative}, 0);
            chk("rst_sp_out", bus.sp_out, 0);
        end else begin
            chk("req_ready", bus.req_ready, !m_busy);
            chk("busy", bus.busy, m_busy);
            chk("resp_valid", bus.resp_valid, m_done);
            chk("mem_write", bus.mem_write, (m_left > 0) && is_wr(m_op));
            if (m_left > 0) begin
                chk("mem_address", bus.mem_address, m_addr);
                if (is_wr(m_op)) chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
            if (m_done) begin
                chk("resp_rdata", bus.resp_rdata, m_rdata);
                chk("resp_zero", bus.resp_zero, !is_wr(m_op) && (m_rdata == 16'h0000));
                chk("resp_negative", bus.resp_negative, !is_wr(m_op) && m_rdata[15]);
                chk("sp_we", bus.sp_we, is_stk(m_op));
                if (is_stk(m_op)) chk("sp_out", bus.sp_out, m_sp);
            end
        end
    end

    // Issue one request from a negedge and return at the negedge showing resp_valid.
    task automatic do_req(input k16_op_e op, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] sp, input int nhold, input bit rnd,
                          output int lat, output int wcnt, output logic [15:0] aaddr,
                          output logic [15:0] rdata, output logic z, output logic n,
                          output logic spwe, output logic [15:0] spo);
        bit got;
        for (int g = 0; g < 20 && !bus.req_ready; g++) @(negedge clk);
        if (!bus.req_ready) timeout("req_ready_wait");
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.sp_in     = sp;
        bus.mem_hold  = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
        @(negedge clk);
        lat = 0; wcnt = 0; got = 1'b0;
        aaddr = 16'h0; rdata = 16'h0; z = 1'b0; n = 1'b0; spwe = 1'b0; spo = 16'h0;
        for (int i = 0; i < 60 && !got; i++) begin
            lat++;
            if (lat == 1) aaddr = bus.mem_address;
            if (bus.mem_write) wcnt++;
            if (bus.resp_valid) begin
                rdata = bus.resp_rdata; z = bus.resp_zero; n = bus.resp_negative;
                spwe = bus.sp_we; spo = bus.sp_out;
                got = 1'b1;
                bus.req_valid = 1'b0;
                bus.mem_hold  = rnd ? ($urandom_range(0, 1) == 0) : 1'b0;
            end else begin
                bus.mem_hold = (lat <= nhold) ? 1'b1 : (rnd ? ($urandom_range(0, 2) == 0) : 1'b0);
                // Stray requests while busy must be ignored.
                bus.req_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                if (rnd) begin
                    bus.req_op   = k16_op_e'($urandom_range(0, 3));
                    bus.req_addr = 16'($urandom);
                end
                @(negedge clk);
            end
        end
        if (!got) timeout("resp_valid_wait");
    endtask

    int          lat, wcnt, last_acc, nacc;
    logic [15:0] aaddr, rd, spo, wd, addr2;
    logic        z, n, spwe;
    k16_op_e     op;
    int          qc[$];
    logic [15:0] qd[$];

    initial begin
        bus.req_valid = 1'b0; bus.req_op = OP_LD; bus.req_addr = '0; bus.req_wdata = '0;
        bus.sp_in = '0; bus.mem_hold = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_op = OP_LD; bus2.req_addr = '0; bus2.req_wdata = '0;
        bus2.sp_in = '0; bus2.mem_hold = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rst2_n = 1'b1;

        // LD with negative data, first request right after reset release.
        do_req(OP_LD, 16'h0040, 16'h0, 16'h0, 0, 0, lat, wcnt, aaddr, rd, z, n, spwe, spo);
        chk("ld_latency", lat, 3);
        chk("ld_rdata", rd, 16'h8000);
        chk("ld_negative", n, 1);
        chk("ld_zero", z, 0);
        chk("ld_sp_we", spwe, 0);

        // ST stalled for two access cycles.
        do_req(OP_ST, 16'h0010, 16'h1234, 16'h0, 2, 0, lat, wcnt, aaddr, rd, z, n, spwe, spo);
        chk("st_write_cycles", wcnt, 4);
        chk("st_address", aaddr, 16'h0010);
        chk("st_latency", lat, 5);
        chk("st_rdata", rd, 16'h0000);
        chk("st_mem", mem[16'h0010], 16'h1234);

        // POP across the top of memory.
        do_req(OP_POP, 16'h0, 16'h0, 16'hFFFF, 0, 0, lat, wcnt, aaddr, rd, z, n, spwe, spo);
        chk("pop_address", aaddr, 16'h0000);
        chk("pop_sp_out", spo, 16'h0000);
        chk("pop_zero", z, 1);
        chk("pop_sp_we", spwe, 1);
        chk("pop_no_write", wcnt, 0);

        // PSH with SP wrap-around.
        do_req(OP_PSH, 16'h0, 16'hBEEF, 16'h0000, 0, 0, lat, wcnt, aaddr, rd, z, n, spwe, spo);
        chk("psh_address", aaddr, 16'h0000);
        chk("psh_sp_out", spo, 16'hFFFF);
        chk("psh_sp_we", spwe, 1);
        chk("psh_write_cycles", wcnt, 2);
        chk("psh_mem", mem[16'h0000], 16'hBEEF);

        // Reset in the middle of a store.
        for (int g = 0; g < 10 && !bus.req_ready; g++) @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = OP_ST; bus.req_addr = 16'h0020;
        bus.req_wdata = 16'h5555; bus.mem_hold = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort_write_before", bus.mem_write, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_write_async", bus.mem_write, 0);
        chk("abort_busy_async", bus.busy, 0);
        chk("abort_resp_valid", bus.resp_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(OP_LD, 16'h0020, 16'h0, 16'h0, 0, 0, lat, wcnt, aaddr, rd, z, n, spwe, spo);
        chk("after_abort_latency", lat, 3);
        chk("after_abort_rdata", rd, 16'h0F0F);

        // Randomized traffic against the model.
        for (int t = 0; t < 300; t++) begin
            op = k16_op_e'($urandom_range(0, 3));
            wd = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            do_req(op, 16'($urandom_range(0, 31)), wd, 16'($urandom_range(0, 7)) - 16'd4,
                   0, 1, lat, wcnt, aaddr, rd, z, n, spwe, spo);
        end
        bus.mem_hold = 1'b0;

        // WAIT_STATES=0 instance: back-to-back loads with req_valid held.
        addr2 = 16'h0100; last_acc = -1; nacc = 0;
        bus2.req_op = OP_LD; bus2.req_addr = addr2;
        for (int c = 0; c < 45; c++) begin
            bus2.req_valid = (c < 39);
            if (bus2.busy) chk("b2b_ready_low", bus2.req_ready, 0);
            if (bus2.resp_valid) begin
                if (qc.size() == 0) timeout("b2b_unexpected_resp");
                else begin
                    chk("b2b_latency", c - qc.pop_front(), 2);
                    chk("b2b_rdata", bus2.resp_rdata, qd.pop_front());
                end
            end
            if (bus2.req_ready && bus2.req_valid) begin
                if (last_acc >= 0) chk("b2b_period", c - last_acc, 3);
                last_acc = c;
                nacc++;
                qc.push_back(c);
                qd.push_back(addr2 ^ 16'hA5A5);
                @(negedge clk);
                addr2 = addr2 + 16'h0111;
                bus2.req_addr = addr2;
            end else begin
                @(negedge clk);
            end
        end
        chk("b2b_accepts", nacc, 13);
        chk("b2b_drained", qc.size(), 0);

        // Upward stack on the second instance.
        bus2.req_valid = 1'b1; bus2.req_op = OP_POP; bus2.sp_in = 16'h0000;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        chk("up_pop_address", bus2.mem_address, 16'hFFFF);
        chk("up_pop_no_write", bus2.mem_write, 0);
        @(negedge clk);
        chk("up_pop_resp_valid", bus2.resp_valid, 1);
        chk("up_pop_sp_we", bus2.sp_we, 1);
        chk("up_pop_sp_out", bus2.sp_out, 16'hFFFF);
        chk("up_pop_rdata", bus2.resp_rdata, 16'h5A5A);
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_op = OP_PSH; bus2.sp_in = 16'hFFFF; bus2.req_wdata = 16'h1111;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        chk("up_psh_address", bus2.mem_address, 16'hFFFF);
        chk("up_psh_write", bus2.mem_write, 1);
        chk("up_psh_wdata", bus2.mem_wdata, 16'h1111);
        @(negedge clk);
        chk("up_psh_resp_valid", bus2.resp_valid, 1);
        chk("up_psh_sp_out", bus2.sp_out, 16'h0000);
        chk("up_psh_rdata", bus2.resp_rdata, 16'h0000);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/k16_lsu.md
K16_LSU -- requirements
Module: k16_lsu

Interface
REQ-001 Parameter DATA_W, default 16, data bus width in bits.
REQ-002 Parameter ADDR_W, default 16, address bus width in bits.
REQ-003 Parameter WAIT_STATES, default 1, range 0..15, extra memory cycles per access.
REQ-004 Parameter STACK_DOWN, default 1, selects stack direction: 1 = push decrements SP, 0 = push increments SP.
REQ-005 The block SHALL have these ports:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, asynchronous, active-low.
- req_valid, input, 1, request present.
- req_ready, output, 1, block can accept a request.
- req_op, input, 2, operation: 0 LD, 1 ST, 2 PSH, 3 POP.
- req_addr, input, ADDR_W, effective address for LD/ST.
- req_wdata, input, DATA_W, store/push data.
- sp_in, input, ADDR_W, current stack pointer.
- resp_valid, output, 1, one-cycle completion pulse.
- resp_rdata, output, DATA_W, load/pop data.
- resp_zero, output, 1, load/pop data equals zero.
- resp_negative, output, 1, load/pop data MSB.
- sp_out, output, ADDR_W, updated stack pointer.
- sp_we, output, 1, sp_out valid, coincident with resp_valid.
- mem_address, output, ADDR_W, memory address.
- mem_wdata, output, DATA_W, memory write data.
- mem_write, output, 1, memory write strobe.
- mem_rdata, input, DATA_W, memory read data.
- mem_hold, input, 1, memory stall; freezes the wait count.
- busy, output, 1, high whenever the state is not IDLE.

Function
REQ-006 The FSM SHALL have the states IDLE, ACCESS and DONE.
REQ-007 req_ready SHALL equal (state==IDLE); a request SHALL be accepted on a rising edge with req_valid and req_ready both high.
REQ-008 req_valid outside IDLE SHALL be ignored, with no queuing.
REQ-009 On acceptance, mem_address, mem_wdata and the op SHALL be registered, the wait counter loaded with WAIT_STATES, and the state set to ACCESS.
REQ-010 The access address SHALL be set per op:
- LD/ST: req_addr.
- PSH: sp_in.
- POP: sp_in+1 (STACK_DOWN=1) or sp_in-1 (STACK_DOWN=0).
REQ-011 mem_write SHALL be high throughout ACCESS for ST/PSH and low otherwise.
REQ-012 In ACCESS, the counter SHALL decrement only when mem_hold is low; when the counter is 0 and mem_hold is low, the state SHALL become DONE.
REQ-013 On the ACCESS-exit edge, LD/POP SHALL capture mem_rdata into resp_rdata, set resp_zero=(mem_rdata==0) and resp_negative=mem_rdata[DATA_W-1].
REQ-014 ST/PSH SHALL drive resp_rdata, resp_zero and resp_negative to 0.
REQ-015 In DONE, resp_valid SHALL be high for exactly one cycle, then the state SHALL return to IDLE.
REQ-016 Latency from acceptance to resp_valid with no hold SHALL be WAIT_STATES+2 cycles; each held cycle adds one.
REQ-017 sp_we SHALL pulse with resp_valid for PSH and POP only.
REQ-018 For PSH, sp_out SHALL be sp_in-1 (STACK_DOWN=1) or sp_in+1 (STACK_DOWN=0).
REQ-019 For POP, sp_out SHALL be the access address.
REQ-020 Stack arithmetic SHALL wrap modulo 2^ADDR_W with no error indication.
REQ-021 mem_hold asserted in IDLE or DONE SHALL have no effect.

Reset
REQ-022 On reset low, the block SHALL asynchronously set state=IDLE and clear mem_write, resp_valid, sp_we, busy, mem_address, mem_wdata, resp_rdata, resp_zero, resp_negative and sp_out to 0.
REQ-023 Reset asserted mid-ACCESS SHALL abort the access immediately, with mem_write low in the same instant and no response generated.
REQ-024 The first request SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-025 Op encodings (LD/ST/PSH/POP) and state encodings SHALL reside in shared package k16_pkg for reuse by the CPU decoder.
REQ-026 The wait counter SHALL be a sub-module k16_wait_timer: load, hold-gated decrement, and a zero flag.

Verification
REQ-027 WAIT_STATES=1, LD req_addr=0x0040, memory[0x0040]=0x8000 -> resp_valid 3 cycles after acceptance, resp_rdata=0x8000, resp_negative=1, resp_zero=0.
REQ-028 ST req_addr=0x0010, req_wdata=0x1234, mem_hold high for 2 ACCESS cycles -> mem_write high 4 cycles at address 0x0010, resp_valid at latency 5.
REQ-029 STACK_DOWN=1, PSH sp_in=0x0000, data 0xBEEF -> write at 0x0000, sp_out=0xFFFF (wrap-around), sp_we with resp_valid.
REQ-030 STACK_DOWN=1, POP sp_in=0xFFFF, memory[0x0000]=0x0000 -> read at 0x0000, sp_out=0x0000, resp_zero=1.
REQ-031 Reset low during ST ACCESS -> mem_write and busy drop asynchronously, no resp_valid; a following LD completes normally.
REQ-032 WAIT_STATES=0, back-to-back LD requests held valid -> one accepted every 3 cycles, req_ready low while busy.
